mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences the single D-cache port between speculative loads, issued from the memory issue queue / load queue, and committed stores drained from the store queue head. Keeps a count of committed-but-undrained stores. Runs one D-cache transaction at a time through a request/complete FSM. Squashes load responses on branch misprediction; committed stores are never squashed. Sits between the load/store queue state and the d_cache controls.

Parameters:
LSQ_SIZE, 8, load/store queue depth (power of 2); index width LSQ_IDX_W = $clog2(LSQ_SIZE)
ADDR_W, 32, memory address width
DATA_W, 32, store data width
STARVE_LIMIT, 4, consecutive load grants allowed while committed stores are pending

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ld_req_valid  in  1  load ready to access cache
ld_req_idx  in  LSQ_IDX_W  load queue entry
ld_req_addr  in  ADDR_W  load address
ld_req_ready  out  1  load accepted this cycle (combinational, IDLE only)
st_commit_valid  in  1  one store committed this cycle
st_head_addr  in  ADDR_W  address at store queue read pointer
st_head_data  in  DATA_W  data at store queue read pointer
st_drain  out  1  one-cycle pulse: advance store queue read pointer
branch_miss  in  1  misprediction flush
dc_req_valid  out  1  cache request valid
dc_req_write  out  1  1 = store, 0 = load
dc_req_addr  out  ADDR_W  request address
dc_req_wdata  out  DATA_W  store data
dc_req_idx  out  LSQ_IDX_W  load entry index (0 for stores)
dc_req_ready  in  1  cache accepted request
dc_done  in  1  cache transaction complete (hit or miss refill)
ld_resp_valid  out  1  load completed, not squashed
ld_resp_idx  out  LSQ_IDX_W  completed load entry
st_pending  out  LSQ_IDX_W+1  committed stores not yet drained
st_empty  out  1  st_pending == 0 and no store in flight

Behaviour:
- Async reset: FSM = IDLE, st_pending = 0, starve_cnt = 0, squash = 0. All outputs are 0; st_empty = 1.
- States:
  - IDLE: arbitrate. On grant, latch the request fields and go to REQ next cycle. The grant cycle is N; dc_req_valid is high from N+1.
  - REQ: dc_req_valid = 1. Fields stay stable until dc_req_ready. On dc_req_ready, go to WAIT. If dc_done arrives in the same cycle as dc_req_ready, complete directly and go to IDLE.
  - WAIT: hold until dc_done, then complete and go to IDLE.
- Completion:
  - Store: st_drain pulses 1 cycle; st_pending decrements.
  - Load: ld_resp_valid pulses 1 cycle with the latched index, unless squash = 1.
  - squash clears on completion.
  - The next grant is possible in the cycle after completion, because IDLE is re-entered then.
- Arbitration in IDLE (priority order):
  1. branch_miss: no load grant; a store may still be granted.
  2. st_pending == LSQ_SIZE: store forced.
  3. st_pending > 0 and starve_cnt == STARVE_LIMIT: store.
  4. ld_req_valid: load, and starve_cnt++ if st_pending > 0.
  5. st_pending > 0: store.
  - Any store grant clears starve_cnt. starve_cnt also clears when st_pending == 0.
- st_pending:
  - Increment on st_commit_valid; decrement on store completion.
  - If both happen in the same cycle, the value is unchanged.
  - Commit while st_pending == LSQ_SIZE with no completion is illegal: the count holds and a simulation assertion fires.
- branch_miss while a load is in REQ or WAIT sets squash. The transaction still finishes (the cache cannot abort); ld_resp_valid is suppressed.
- branch_miss never affects store transactions or st_pending.
- dc_done outside REQ/WAIT is ignored, with an assertion.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds outputs perf_ld_grants, perf_st_grants and perf_starve_overrides (32-bit each, reset 0, wrap at 2^32).
  - perf_ld_grants increments on each load grant.
  - perf_st_grants increments on each store grant.
  - perf_starve_overrides increments on each store grant that came from rule 3.
- Undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset mid-WAIT with st_pending = 3 -> all outputs 0 immediately, st_empty = 1, FSM in IDLE after release.
- Single load at idx 5, addr 0x100; dc_req_ready at N+1, dc_done at N+3 -> dc_req_write = 0, ld_resp_valid with idx 5 at N+3, ld_req_ready high only at N.
- st_pending = 2 and ld_req_valid held high, STARVE_LIMIT = 4 -> grants: 4 loads, 1 store, 4 loads, 1 store; st_drain pulses twice; st_pending reaches 0.
- branch_miss during WAIT of load idx 2 -> dc_done still accepted, no ld_resp_valid, next load in IDLE granted normally.
- st_pending = 8 (LSQ_SIZE = 8) with ld_req_valid high -> store forced. A commit pulse coinciding with that store's completion leaves st_pending = 8.
- dc_req_ready and dc_done in the same cycle for store addr 0x40, data 0xDEADBEEF -> st_drain that cycle, IDLE next cycle, st_pending decremented by 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single D-cache port between speculative loads and committed store drain.
// Define MEM_ARB_PERF_EN to add the perf_* grant counters.
module mem_port_arbiter #(
    parameter int  LSQ_SIZE     = 8,
    parameter int  ADDR_W       = 32,
    parameter int  DATA_W       = 32,
    parameter int  STARVE_LIMIT = 4,
    localparam int LSQ_IDX_W    = $clog2(LSQ_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_req_valid,
    input  logic [LSQ_IDX_W-1:0] ld_req_idx,
    input  logic [ADDR_W-1:0]    ld_req_addr,
    output logic                 ld_req_ready,
    input  logic                 st_commit_valid,
    input  logic [ADDR_W-1:0]    st_head_addr,
    input  logic [DATA_W-1:0]    st_head_data,
    output logic                 st_drain,
    input  logic                 branch_miss,
    output logic                 dc_req_valid,
    output logic                 dc_req_write,
    output logic [ADDR_W-1:0]    dc_req_addr,
    output logic [DATA_W-1:0]    dc_req_wdata,
    output logic [LSQ_IDX_W-1:0] dc_req_idx,
    input  logic                 dc_req_ready,
    input  logic                 dc_done,
    output logic                 ld_resp_valid,
    output logic [LSQ_IDX_W-1:0] ld_resp_idx,
    output logic [LSQ_IDX_W:0]   st_pending,
    output logic                 st_empty
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_ld_grants,
    output logic [31:0]          perf_st_grants,
    output logic [31:0]          perf_starve_overrides
`endif
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LSQ_IDX_W:0]  PEND_FULL   = (LSQ_IDX_W+1)'(LSQ_SIZE);
    localparam logic [STARVE_W-1:0] STARVE_MAX  = STARVE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                state_q;
    logic [LSQ_IDX_W:0]    st_pending_q, st_pending_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  squash_q;
    logic                  dc_req_valid_q;
    logic                  dc_req_write_q;
    logic [ADDR_W-1:0]     dc_req_addr_q;
    logic [DATA_W-1:0]     dc_req_wdata_q;
    logic [LSQ_IDX_W-1:0]  dc_req_idx_q;

    logic is_idle, pend_nz, pend_full, starve_hit;
    logic grant_ld, grant_st, starve_ovr;
    logic complete, st_done, ld_done, commit_ovf, commit_inc;

    assign is_idle    = (state_q == S_IDLE);
    assign pend_nz    = (st_pending_q != '0);
    assign pend_full  = (st_pending_q == PEND_FULL);
    assign starve_hit = (starve_q == STARVE_MAX);

    always_comb begin
        grant_ld   = 1'b0;
        grant_st   = 1'b0;
        starve_ovr = 1'b0;
        if (is_idle) begin
            if (pend_full) begin
                grant_st = 1'b1;
            end else if (pend_nz && starve_hit) begin
                grant_st   = 1'b1;
                starve_ovr = 1'b1;
            end else if (ld_req_valid && !branch_miss) begin
                grant_ld = 1'b1;
            end else if (pend_nz) begin
                grant_st = 1'b1;
            end
        end
    end

    // Completion is taken in the same cycle dc_done is seen, including the REQ fast path.
    assign complete   = ((state_q == S_REQ) && dc_req_ready && dc_done) ||
                        ((state_q == S_WAIT) && dc_done);
    assign st_done    = complete && dc_req_write_q;
    assign ld_done    = complete && !dc_req_write_q;
    assign commit_ovf = st_commit_valid && pend_full && !st_done;
    assign commit_inc = st_commit_valid && !commit_ovf;

    always_comb begin
        st_pending_d = st_pending_q;
        case ({commit_inc, st_done})
            2'b10:   st_pending_d = st_pending_q + (LSQ_IDX_W+1)'(1);
            2'b01:   st_pending_d = st_pending_q - (LSQ_IDX_W+1)'(1);
            default: st_pending_d = st_pending_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (grant_st || !pend_nz) begin
            starve_d = '0;
        end else if (grant_ld) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            st_pending_q   <= '0;
            starve_q       <= '0;
            squash_q       <= 1'b0;
            dc_req_valid_q <= 1'b0;
            dc_req_write_q <= 1'b0;
            dc_req_addr_q  <= '0;
            dc_req_wdata_q <= '0;
            dc_req_idx_q   <= '0;
        end else begin
            st_pending_q <= st_pending_d;
            starve_q     <= starve_d;

            if (complete) begin
                squash_q <= 1'b0;
            end else if (branch_miss && !is_idle && !dc_req_write_q) begin
                squash_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (grant_st || grant_ld) begin
                        state_q        <= S_REQ;
                        dc_req_valid_q <= 1'b1;
                        dc_req_write_q <= grant_st;
                        dc_req_addr_q  <= grant_st ? st_head_addr : ld_req_addr;
                        dc_req_wdata_q <= grant_st ? st_head_data : '0;
                        dc_req_idx_q   <= grant_st ? '0 : ld_req_idx;
                    end
                end
                S_REQ: begin
                    if (dc_req_ready) begin
                        dc_req_valid_q <= 1'b0;
                        state_q        <= dc_done ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dc_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    dc_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ld_req_ready  = grant_ld;
    assign st_drain      = st_done;
    // A flush arriving in the completion cycle itself still kills the response.
    assign ld_resp_valid = ld_done && !squash_q && !branch_miss;
    assign ld_resp_idx   = ld_resp_valid ? dc_req_idx_q : '0;
    assign dc_req_valid  = dc_req_valid_q;
    assign dc_req_write  = dc_req_write_q;
    assign dc_req_addr   = dc_req_addr_q;
    assign dc_req_wdata  = dc_req_wdata_q;
    assign dc_req_idx    = dc_req_idx_q;
    assign st_pending    = st_pending_q;
    assign st_empty      = !pend_nz && !(!is_idle && dc_req_write_q);

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ld_grants        <= '0;
            perf_st_grants        <= '0;
            perf_starve_overrides <= '0;
        end else begin
            if (grant_ld)   perf_ld_grants        <= perf_ld_grants + 32'd1;
            if (grant_st)   perf_st_grants        <= perf_st_grants + 32'd1;
            if (starve_ovr) perf_starve_overrides <= perf_starve_overrides + 32'd1;
        end
    end
`endif

    a_commit_overflow: assert property (@(posedge clk) disable iff (!rst_n) !commit_ovf);
    a_done_in_idle:    assert property (@(posedge clk) disable iff (!rst_n) !(dc_done && is_idle));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios and randomized traffic checked
// against a transaction-level model of the port arbitration rules.
module tb_mem_port_arbiter;
    localparam int LSQ_SIZE     = 8;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int IDX_W        = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_req_valid = 1'b0;
    logic [IDX_W-1:0]  ld_req_idx = '0;
    logic [ADDR_W-1:0] ld_req_addr = '0;
    logic              ld_req_ready;
    logic              st_commit_valid = 1'b0;
    logic [ADDR_W-1:0] st_head_addr = '0;
    logic [DATA_W-1:0] st_head_data = '0;
    logic              st_drain;
    logic              branch_miss = 1'b0;
    logic              dc_req_valid;
    logic              dc_req_write;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_wdata;
    logic [IDX_W-1:0]  dc_req_idx;
    logic              dc_req_ready = 1'b0;
    logic              dc_done = 1'b0;
    logic              ld_resp_valid;
    logic [IDX_W-1:0]  ld_resp_idx;
    logic [IDX_W:0]    st_pending;
    logic              st_empty;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_ld_grants, perf_st_grants, perf_starve_overrides;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: pending-store count, loads granted since last store, and the one open transaction.
    int                m_pend;
    int                m_starve;
    bit                m_busy, m_acc, m_wr, m_sq;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [IDX_W-1:0]  m_idx;
    int                e_grant;     // 0 none, 1 load, 2 store
    bit                e_complete;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .LSQ_SIZE(LSQ_SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_req_valid(ld_req_valid), .ld_req_idx(ld_req_idx), .ld_req_addr(ld_req_addr),
        .ld_req_ready(ld_req_ready),
        .st_commit_valid(st_commit_valid), .st_head_addr(st_head_addr), .st_head_data(st_head_data),
        .st_drain(st_drain), .branch_miss(branch_miss),
        .dc_req_valid(dc_req_valid), .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_idx(dc_req_idx),
        .dc_req_ready(dc_req_ready), .dc_done(dc_done),
        .ld_resp_valid(ld_resp_valid), .ld_resp_idx(ld_resp_idx),
        .st_pending(st_pending), .st_empty(st_empty)
`ifdef MEM_ARB_PERF_EN
        , .perf_ld_grants(perf_ld_grants), .perf_st_grants(perf_st_grants),
        .perf_starve_overrides(perf_starve_overrides)
`endif
    );

    task automatic model_reset();
        m_pend = 0; m_starve = 0;
        m_busy = 0; m_acc = 0; m_wr = 0; m_sq = 0;
        m_addr = '0; m_wdata = '0; m_idx = '0;
        e_grant = 0; e_complete = 0;
    endtask

    task automatic clear_inputs();
        ld_req_valid = 0; ld_req_idx = '0; ld_req_addr = '0;
        st_commit_valid = 0; branch_miss = 0;
        dc_req_ready = 0; dc_done = 0;
    endtask

    task automatic model_eval();
        e_grant = 0;
        if (!m_busy) begin
            if (m_pend == LSQ_SIZE)                              e_grant = 2;
            else if (m_pend > 0 && m_starve == STARVE_LIMIT)     e_grant = 2;
            else if (ld_req_valid && !branch_miss)               e_grant = 1;
            else if (m_pend > 0)                                 e_grant = 2;
        end
        e_complete = m_busy && dc_done && (m_acc || dc_req_ready);
    endtask

    task automatic model_update();
        int old_pend;
        bit st_done;
        old_pend = m_pend;
        st_done  = e_complete && m_wr;
        if (st_commit_valid && (m_pend < LSQ_SIZE || st_done)) m_pend = m_pend + 1;
        if (st_done) m_pend = m_pend - 1;
        if (e_grant == 2 || old_pend == 0) m_starve = 0;
        else if (e_grant == 1)             m_starve = m_starve + 1;
        if (e_complete) begin
            m_busy = 0; m_sq = 0;
        end else if (m_busy) begin
            if (!m_wr && branch_miss) m_sq = 1;
            if (!m_acc && dc_req_ready) m_acc = 1;
        end
        if (e_grant != 0) begin
            m_busy  = 1; m_acc = 0; m_sq = 0;
            m_wr    = (e_grant == 2);
            m_addr  = m_wr ? st_head_addr : ld_req_addr;
            m_wdata = m_wr ? st_head_data : '0;
            m_idx   = m_wr ? '0 : ld_req_idx;
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at the falling edge.
    task automatic settle();
        #4;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic finish_txn();
        for (int i = 0; i < 8 && m_busy; i++) begin
            clear_inputs();
            dc_req_ready = m_busy && !m_acc;
            dc_done      = m_busy && m_acc;
            settle();
            advance();
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < 200 && (m_busy || m_pend != 0); i++) begin
            clear_inputs();
            dc_req_ready = m_busy && !m_acc;
            dc_done      = m_busy && m_acc;
            settle();
            advance();
        end
    endtask

    task automatic test_reset();
        model_reset();
        clear_inputs();
        rst_n = 0;
        #1;
        n_checks++; if (dc_req_valid !== 1'b0) $display("FAIL por_req_valid: got %b want 0", dc_req_valid); else n_pass++;
        n_checks++; if (st_empty !== 1'b1) $display("FAIL por_st_empty: got %b want 1", st_empty); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        // build three pending stores with one in WAIT
        clear_inputs(); st_commit_valid = 1; settle(); advance();
        clear_inputs(); st_commit_valid = 1; st_head_addr = 32'h10; st_head_data = 32'h1111;
        settle(); advance();
        clear_inputs(); st_commit_valid = 1; dc_req_ready = 1; settle(); advance();
        clear_inputs(); settle();
        n_checks++; if (st_pending !== 4'd3) $display("FAIL pre_rst_pending: got %0d want 3", st_pending); else n_pass++;
        n_checks++; if (dc_req_write !== 1'b1) $display("FAIL pre_rst_inflight: got %b want 1", dc_req_write); else n_pass++;
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if ({dc_req_valid, dc_req_write, st_drain, ld_resp_valid, ld_req_ready} !== 5'b0 ||
            dc_req_addr !== '0 || dc_req_wdata !== '0 || dc_req_idx !== '0 || ld_resp_idx !== '0)
            $display("FAIL rst_outputs_zero: got v%b w%b d%b r%b rdy%b addr%h", dc_req_valid, dc_req_write,
                     st_drain, ld_resp_valid, ld_req_ready, dc_req_addr);
        else n_pass++;
        n_checks++; if (st_pending !== 4'd0) $display("FAIL rst_pending: got %0d want 0", st_pending); else n_pass++;
        n_checks++; if (st_empty !== 1'b1) $display("FAIL rst_st_empty: got %b want 1", st_empty); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd1; ld_req_addr = 32'h80;
        settle();
        n_checks++; if (ld_req_ready !== 1'b1) $display("FAIL rst_idle_after: ld_req_ready got %b want 1", ld_req_ready); else n_pass++;
        advance();
        finish_txn();
    endtask

    task automatic test_single_load();
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd5; ld_req_addr = 32'h100;
        settle();
        n_checks++; if (ld_req_ready !== 1'b1) $display("FAIL sl_ready_N: got %b want 1", ld_req_ready); else n_pass++;
        n_checks++; if (dc_req_valid !== 1'b0) $display("FAIL sl_valid_N: got %b want 0", dc_req_valid); else n_pass++;
        advance();
        dc_req_ready = 1;
        settle();
        n_checks++;
        if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b0 || dc_req_addr !== 32'h100 || dc_req_idx !== 3'd5)
            $display("FAIL sl_req_N1: got v%b w%b a%h i%0d want v1 w0 a100 i5", dc_req_valid, dc_req_write, dc_req_addr, dc_req_idx);
        else n_pass++;
        n_checks++; if (ld_req_ready !== 1'b0) $display("FAIL sl_ready_N1: got %b want 0", ld_req_ready); else n_pass++;
        advance();
        dc_req_ready = 0;
        settle();
        n_checks++;
        if (dc_req_valid !== 1'b0 || ld_req_ready !== 1'b0 || ld_resp_valid !== 1'b0)
            $display("FAIL sl_wait_N2: got v%b rdy%b resp%b want 000", dc_req_valid, ld_req_ready, ld_resp_valid);
        else n_pass++;
        advance();
        dc_done = 1;
        settle();
        n_checks++;
        if (ld_resp_valid !== 1'b1 || ld_resp_idx !== 3'd5)
            $display("FAIL sl_resp_N3: got v%b idx%0d want v1 idx5", ld_resp_valid, ld_resp_idx);
        else n_pass++;
        n_checks++; if (ld_req_ready !== 1'b0) $display("FAIL sl_ready_N3: got %b want 0", ld_req_ready); else n_pass++;
        advance();
        clear_inputs();
        settle();
        n_checks++; if (ld_resp_valid !== 1'b0) $display("FAIL sl_resp_pulse: got %b want 0", ld_resp_valid); else n_pass++;
        advance();
    endtask

    task automatic test_starvation();
        int        n_obs, n_drain, n_ldrdy;
        logic [9:0] got;
        n_obs = 0; n_drain = 0; n_ldrdy = 0; got = '0;
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd3; ld_req_addr = 32'h300; st_commit_valid = 1;
        settle(); advance();
        clear_inputs(); st_commit_valid = 1; dc_req_ready = 1; settle(); advance();
        clear_inputs(); dc_done = 1; settle(); advance();
        for (int c = 0; c < 150; c++) begin
            clear_inputs();
            ld_req_valid = (n_obs < 10);
            ld_req_idx   = IDX_W'(c);
            ld_req_addr  = 32'h1000 + 32'(c);
            st_head_addr = 32'h2000 + 32'(c);
            st_head_data = $urandom();
            dc_req_ready = m_busy && !m_acc;
            dc_done      = m_busy && m_acc;
            settle();
            if (dc_req_valid === 1'b1 && n_obs < 10) begin
                got[n_obs] = dc_req_write;
                n_obs++;
            end
            if (st_drain === 1'b1) n_drain++;
            if (ld_req_ready === 1'b1) n_ldrdy++;
            advance();
            if (n_obs >= 10 && !m_busy) break;
        end
        n_checks++; if (n_obs != 10) $display("FAIL starve_grant_count: got %0d want 10", n_obs); else n_pass++;
        n_checks++; if (got !== 10'h210) $display("FAIL starve_pattern: got %b want 1000010000", got); else n_pass++;
        n_checks++; if (n_drain != 2) $display("FAIL starve_drains: got %0d want 2", n_drain); else n_pass++;
        n_checks++; if (n_ldrdy != 8) $display("FAIL starve_ld_grants: got %0d want 8", n_ldrdy); else n_pass++;
        clear_inputs(); settle();
        n_checks++; if (st_pending !== 4'd0) $display("FAIL starve_pending_end: got %0d want 0", st_pending); else n_pass++;
        n_checks++; if (st_empty !== 1'b1) $display("FAIL starve_empty_end: got %b want 1", st_empty); else n_pass++;
        advance();
    endtask

    task automatic test_branch_miss();
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd2; ld_req_addr = 32'h220;
        settle(); advance();
        clear_inputs(); dc_req_ready = 1; settle(); advance();
        clear_inputs(); branch_miss = 1; settle();
        n_checks++; if (ld_resp_valid !== 1'b0) $display("FAIL bm_resp_early: got %b want 0", ld_resp_valid); else n_pass++;
        advance();
        clear_inputs(); dc_done = 1; settle();
        n_checks++; if (ld_resp_valid !== 1'b0) $display("FAIL bm_squashed: got %b want 0", ld_resp_valid); else n_pass++;
        advance();
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd6; ld_req_addr = 32'h200; settle();
        n_checks++; if (ld_req_ready !== 1'b1) $display("FAIL bm_next_grant: got %b want 1", ld_req_ready); else n_pass++;
        advance();
        clear_inputs(); dc_req_ready = 1; dc_done = 1; settle();
        n_checks++;
        if (ld_resp_valid !== 1'b1 || ld_resp_idx !== 3'd6)
            $display("FAIL bm_next_resp: got v%b idx%0d want v1 idx6", ld_resp_valid, ld_resp_idx);
        else n_pass++;
        advance();
    endtask

    task automatic test_forced_store();
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd4; ld_req_addr = 32'h400; settle(); advance();
        clear_inputs(); dc_req_ready = 1; settle(); advance();
        for (int i = 0; i < LSQ_SIZE; i++) begin
            clear_inputs(); st_commit_valid = 1; settle(); advance();
        end
        clear_inputs(); dc_done = 1; settle();
        n_checks++; if (st_pending !== 4'd8) $display("FAIL fs_pending_full: got %0d want 8", st_pending); else n_pass++;
        advance();
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd1; ld_req_addr = 32'h480;
        st_head_addr = 32'h500; st_head_data = 32'h55;
        settle();
        n_checks++; if (ld_req_ready !== 1'b0) $display("FAIL fs_load_blocked: got %b want 0", ld_req_ready); else n_pass++;
        advance();
        clear_inputs(); dc_req_ready = 1; settle();
        n_checks++;
        if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b1 || dc_req_addr !== 32'h500 || dc_req_wdata !== 32'h55)
            $display("FAIL fs_store_req: got v%b w%b a%h d%h want v1 w1 a500 d55", dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata);
        else n_pass++;
        advance();
        clear_inputs(); dc_done = 1; st_commit_valid = 1; settle();
        n_checks++; if (st_drain !== 1'b1) $display("FAIL fs_drain: got %b want 1", st_drain); else n_pass++;
        advance();
        clear_inputs(); settle();
        n_checks++; if (st_pending !== 4'd8) $display("FAIL fs_commit_and_drain: got %0d want 8", st_pending); else n_pass++;
        advance();
        drain_all();
        clear_inputs(); settle();
        n_checks++; if (st_pending !== 4'd0) $display("FAIL fs_drained: got %0d want 0", st_pending); else n_pass++;
        advance();
    endtask

    task automatic test_same_cycle_store();
        clear_inputs(); st_commit_valid = 1; st_head_addr = 32'h40; st_head_data = 32'hDEADBEEF;
        settle(); advance();
        clear_inputs(); settle(); advance();
        clear_inputs(); dc_req_ready = 1; dc_done = 1; settle();
        n_checks++;
        if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b1 || dc_req_addr !== 32'h40 ||
            dc_req_wdata !== 32'hDEADBEEF || dc_req_idx !== 3'd0)
            $display("FAIL sc_store_req: got v%b w%b a%h d%h i%0d want v1 w1 a40 dDEADBEEF i0",
                     dc_req_valid, dc_req_write, dc_req_addr, dc_req_wdata, dc_req_idx);
        else n_pass++;
        n_checks++; if (st_drain !== 1'b1) $display("FAIL sc_drain: got %b want 1", st_drain); else n_pass++;
        n_checks++; if (st_pending !== 4'd1) $display("FAIL sc_pending_before: got %0d want 1", st_pending); else n_pass++;
        advance();
        clear_inputs(); ld_req_valid = 1; ld_req_idx = 3'd7; ld_req_addr = 32'h700; settle();
        n_checks++; if (st_pending !== 4'd0) $display("FAIL sc_pending_after: got %0d want 0", st_pending); else n_pass++;
        n_checks++;
        if (ld_req_ready !== 1'b1 || dc_req_valid !== 1'b0 || st_drain !== 1'b0)
            $display("FAIL sc_idle_next: got rdy%b v%b d%b want 1 0 0", ld_req_ready, dc_req_valid, st_drain);
        else n_pass++;
        advance();
        finish_txn();
    endtask

    task automatic test_random();
        bit exp_valid, exp_drain, exp_resp;
        for (int c = 0; c < 3000; c++) begin
            ld_req_valid    = ($urandom_range(0, 99) < 60);
            ld_req_idx      = IDX_W'($urandom_range(0, LSQ_SIZE - 1));
            ld_req_addr     = $urandom();
            st_head_addr    = $urandom();
            st_head_data    = $urandom();
            branch_miss     = ($urandom_range(0, 99) < 8);
            dc_req_ready    = m_busy && !m_acc && ($urandom_range(0, 99) < 50);
            dc_done         = m_busy && (m_acc || dc_req_ready) && ($urandom_range(0, 99) < 40);
            st_commit_valid = ($urandom_range(0, 99) < 30) &&
                              (m_pend < LSQ_SIZE || (m_busy && m_wr && dc_done));
            settle();
            exp_valid = m_busy && !m_acc;
            exp_drain = e_complete && m_wr;
            exp_resp  = e_complete && !m_wr && !m_sq && !branch_miss;
            n_checks++; if (ld_req_ready !== (e_grant == 1)) $display("FAIL rnd_ld_ready c%0d: got %b want %b", c, ld_req_ready, (e_grant == 1)); else n_pass++;
            n_checks++; if (dc_req_valid !== exp_valid) $display("FAIL rnd_req_valid c%0d: got %b want %b", c, dc_req_valid, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (dc_req_write !== m_wr || dc_req_addr !== m_addr || dc_req_wdata !== m_wdata || dc_req_idx !== m_idx)
                    $display("FAIL rnd_req_fields c%0d: got w%b a%h d%h i%0d want w%b a%h d%h i%0d", c,
                             dc_req_write, dc_req_addr, dc_req_wdata, dc_req_idx, m_wr, m_addr, m_wdata, m_idx);
                else n_pass++;
            end
            n_checks++; if (st_drain !== exp_drain) $display("FAIL rnd_drain c%0d: got %b want %b", c, st_drain, exp_drain); else n_pass++;
            n_checks++; if (ld_resp_valid !== exp_resp) $display("FAIL rnd_resp c%0d: got %b want %b", c, ld_resp_valid, exp_resp); else n_pass++;
            if (exp_resp) begin
                n_checks++; if (ld_resp_idx !== m_idx) $display("FAIL rnd_resp_idx c%0d: got %0d want %0d", c, ld_resp_idx, m_idx); else n_pass++;
            end
            n_checks++; if (st_pending !== (IDX_W+1)'(m_pend)) $display("FAIL rnd_pending c%0d: got %0d want %0d", c, st_pending, m_pend); else n_pass++;
            n_checks++; if (st_empty !== (m_pend == 0)) $display("FAIL rnd_empty c%0d: got %b want %b", c, st_empty, (m_pend == 0)); else n_pass++;
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_starvation();
        test_branch_miss();
        test_forced_store();
        test_same_cycle_store();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
